// File: rtl/alu_capture_pkg.sv
// alu_capture_pkg
//   Shared constants and types for the ALU result capture block.
//   DATA_W                 width of the upstream result bus w
//   DEFAULT_DEPTH          default FIFO entries (power of two, >= 2)
//   DEFAULT_SETTLE_CYCLES  default unchanged samples before settled (1..15)
//   CNT_W                  width of change_cnt and of the stable timer
package alu_capture_pkg;

    localparam int DATA_W                = 6;
    localparam int DEFAULT_DEPTH         = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 3;
    localparam int CNT_W                 = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        SETTLED = 2'd2
    } cap_state_e;

endpackage

// File: rtl/alu_result_capture_fifo.sv
// result_fifo
//   Small synchronous FIFO holding captured result values.
//   Pointers carry one extra wrap bit to tell full from empty.
//   A push into a full FIFO is accepted when a pop happens on the same
//   edge, because the pop frees the slot being written.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write request and value
//   push_accepted       push was stored (not dropped)
//   pop                 consumer accept; ignored while empty
//   out_data, out_valid head value and non-empty flag
module result_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         push_accepted,
    input  logic         pop,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop_ok;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok = pop && !empty;

    assign push_accepted = push && (!full || pop_ok);
    assign out_data      = mem[rd_ptr[AW-1:0]];
    assign out_valid     = !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_accepted) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// alu_result_capture
//   Watches the result bus of controller_ALU_0to8, queues every new value
//   for a valid/ready consumer, flags when the bus has stopped changing and
//   flags values lost to a full queue.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   en                      sample enable
//   w_in                    upstream result bus
//   out_data, out_valid     queue head and non-empty flag
//   out_ready               consumer accepts head
//   settled                 bus unchanged for SETTLE_CYCLES enabled samples
//   overflow                sticky: a new value was dropped
//   change_cnt              values queued since reset, saturating at 15
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no baseline yet; next enabled sample is always queued
// TRACK   | baseline held, waiting for SETTLE_CYCLES unchanged samples
// SETTLED | bus stable; settled=1 until the next change
module alu_result_capture
    import alu_capture_pkg::*;
#(
    parameter int W             = DATA_W,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     w_in,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             settled,
    output logic             overflow,
    output logic [CNT_W-1:0] change_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    cap_state_e       state;
    logic [W-1:0]     prev;
    // Down-counter of unchanged samples still needed before settling;
    // parks at zero once settled, so it cannot wrap.
    logic [CNT_W-1:0] settle_left;
    logic             changed;
    logic             push;
    logic             pop;
    logic             push_accepted;

    assign changed = (w_in != prev);
    assign push    = en && ((state == IDLE) || changed);
    assign pop     = out_valid && out_ready;

    result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_data     (w_in),
        .push_accepted (push_accepted),
        .pop           (pop),
        .out_data      (out_data),
        .out_valid     (out_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev        <= '0;
            settle_left <= '0;
            settled     <= 1'b0;
            overflow    <= 1'b0;
            change_cnt  <= '0;
        end else begin
            if (push && !push_accepted) begin
                overflow <= 1'b1;
            end
            if (push_accepted && (change_cnt != CNT_MAX)) begin
                change_cnt <= change_cnt + CNT_ONE;
            end

            // prev follows w_in even when the push is dropped, so a held
            // value is not reported again once space frees up.
            if (en) begin
                case (state)
                    IDLE: begin
                        prev <= w_in;
                        if (SETTLE_CYCLES == 1) begin
                            settle_left <= '0;
                            state       <= SETTLED;
                            settled     <= 1'b1;
                        end else begin
                            settle_left <= SETTLE_LOAD;
                            state       <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (changed) begin
                            prev        <= w_in;
                            settle_left <= SETTLE_LOAD;
                        end else if (settle_left <= CNT_ONE) begin
                            settle_left <= '0;
                            state       <= SETTLED;
                            settled     <= 1'b1;
                        end else begin
                            settle_left <= settle_left - CNT_ONE;
                        end
                    end
                    SETTLED: begin
                        if (changed) begin
                            prev        <= w_in;
                            settle_left <= SETTLE_LOAD;
                            state       <= TRACK;
                            settled     <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        settled <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
module tb_alu_result_capture;
    import alu_capture_pkg::*;

    localparam int W     = 6;
    localparam int DEPTH = 4;
    localparam int SC    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [W-1:0]     w_in;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             settled;
    logic             overflow;
    logic [CNT_W-1:0] change_cnt;

    always #5 clk = ~clk;

    alu_result_capture #(
        .W             (W),
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .w_in       (w_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .settled    (settled),
        .overflow   (overflow),
        .change_cnt (change_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard of values expected from the consumer side, in order.
    logic [W-1:0] sb [$];

    // Reference model (state: 0 idle, 1 tracking, 2 settled).
    int           m_cnt;
    logic [W-1:0] m_prev;
    int           m_stable;
    int           m_state;
    bit           m_ovf;
    int           m_chg;

    typedef struct {
        logic         en;
        logic [W-1:0] w;
        logic         rdy;
        logic         ev;
        logic         es;
        logic         eo;
        int           ec;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt    = 0;
        m_prev   = '0;
        m_stable = 0;
        m_state  = 0;
        m_ovf    = 0;
        m_chg    = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        w_in      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; consumer side compared at the negedge before
    // the pop edge, model advanced at the edge, outputs checked #1 after.
    task automatic step(input logic e, input logic [W-1:0] w, input logic r);
        bit pop;
        bit push;
        en        = e;
        w_in      = w;
        out_ready = r;
        pop = (m_cnt > 0) && r;
        @(negedge clk);
        if (pop) begin
            chk("pop_data", int'(out_data), int'(sb[0]));
            void'(sb.pop_front());
        end
        @(posedge clk);
        push = e && ((m_state == 0) || (w != m_prev));
        if (push) begin
            if ((m_cnt < DEPTH) || pop) begin
                sb.push_back(w);
                m_cnt++;
                if (m_chg < 15) m_chg++;
            end else begin
                m_ovf = 1;
            end
            m_prev = w;
        end
        if (pop) m_cnt--;
        if (e) begin
            if (push) begin
                m_stable = 0;
                m_state  = ((m_state == 0) && (SC == 1)) ? 2 : 1;
            end else begin
                if (m_stable < 15) m_stable++;
                if (m_stable >= SC) m_state = 2;
            end
        end
        #1;
        chk("out_valid", int'(out_valid), int'(m_cnt != 0));
        if (m_cnt != 0) chk("head_data", int'(out_data), int'(sb[0]));
        chk("settled", int'(settled), int'(m_state == 2));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("change_cnt", int'(change_cnt), m_chg);
    endtask

    initial begin
        int seq [9];
        seq = '{0, 1, 3, 0, 4, 20, 14, 2, 10};
        for (int i = 0; i < 9; i++) begin
            tv[i] = '{1'b1, W'(seq[i]), 1'b1, 1'b1, 1'b0, 1'b0, i + 1};
        end
        for (int i = 0; i < 4; i++) begin
            tv[9 + i] = '{1'b1, W'(10), 1'b1, 1'b0, (i >= 2), 1'b0, 9};
        end

        // Reset state
        do_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_settled", int'(settled), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_cnt", int'(change_cnt), 0);

        // Upstream controller sequence, table driven
        for (int i = 0; i < 13; i++) begin
            step(tv[i].en, tv[i].w, tv[i].rdy);
            chk("t2_valid", int'(out_valid), int'(tv[i].ev));
            chk("t2_settled", int'(settled), int'(tv[i].es));
            chk("t2_overflow", int'(overflow), int'(tv[i].eo));
            chk("t2_cnt", int'(change_cnt), tv[i].ec);
        end

        // Overflow with consumer stalled, then drain
        do_reset();
        for (int v = 1; v <= 5; v++) step(1'b1, W'(v), 1'b0);
        step(1'b1, W'(5), 1'b0);
        step(1'b1, W'(5), 1'b0);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_cnt", int'(change_cnt), 4);
        chk("t3_head", int'(out_data), 1);
        repeat (5) step(1'b1, W'(5), 1'b1);
        chk("t3_empty", int'(out_valid), 0);
        chk("t3_ovf_sticky", int'(overflow), 1);

        // Push and pop on the same edge while full
        do_reset();
        for (int v = 1; v <= 4; v++) step(1'b1, W'(v), 1'b0);
        step(1'b1, W'(9), 1'b1);
        chk("t4_overflow", int'(overflow), 0);
        chk("t4_cnt", int'(change_cnt), 5);
        chk("t4_head", int'(out_data), 2);
        repeat (5) step(1'b1, W'(9), 1'b1);
        chk("t4_empty", int'(out_valid), 0);

        // Enable gating of the stable count
        do_reset();
        step(1'b1, W'(7), 1'b1);
        step(1'b1, W'(7), 1'b1);
        step(1'b0, W'(7), 1'b1);
        step(1'b1, W'(7), 1'b1);
        step(1'b0, W'(7), 1'b1);
        chk("t5_not_yet", int'(settled), 0);
        step(1'b1, W'(7), 1'b1);
        chk("t5_settled", int'(settled), 1);
        chk("t5_one_push", int'(change_cnt), 1);

        // Leaving SETTLED and long hold without wrap
        step(1'b1, W'(8), 1'b1);
        chk("t6_drop", int'(settled), 0);
        chk("t6_cnt", int'(change_cnt), 2);
        repeat (20) step(1'b1, W'(8), 1'b1);
        chk("t6_hold", int'(settled), 1);
        chk("t6_cnt_hold", int'(change_cnt), 2);

        // Asynchronous reset mid-stream with two entries queued
        do_reset();
        for (int v = 1; v <= 5; v++) step(1'b1, W'(v), 1'b0);
        repeat (3) step(1'b1, W'(5), 1'b0);
        step(1'b1, W'(5), 1'b1);
        step(1'b1, W'(5), 1'b1);
        out_ready = 1'b0;
        chk("t1_pre_settled", int'(settled), 1);
        chk("t1_pre_overflow", int'(overflow), 1);
        chk("t1_pre_valid", int'(out_valid), 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_valid", int'(out_valid), 0);
        chk("t1_async_data", int'(out_data), 0);
        chk("t1_async_settled", int'(settled), 0);
        chk("t1_async_overflow", int'(overflow), 0);
        chk("t1_async_cnt", int'(change_cnt), 0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        step(1'b1, W'(5), 1'b0);
        chk("t1_first_cnt", int'(change_cnt), 1);
        chk("t1_first_data", int'(out_data), 5);
        step(1'b1, W'(5), 1'b1);
        step(1'b1, W'(5), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
